// File: rtl/dma_read_burst_writer_pkg.sv
// Shared types and widths for the DMA read-burst writer: state encoding,
// beat/dword-enable widths, descriptor field widths and the byte-enable expander.
package dma_read_burst_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_BEAT = 2'd2
  } state_t;

  localparam int BEAT_W = 128;
  localparam int DWEN_W = 4;
  localparam int BE_W   = BEAT_W / 8;
  localparam int ADDR_W = 32;
  localparam int CTR_W  = 8;

  // Each dword enable expands to the four byte enables of its dword lane.
  function automatic logic [BE_W-1:0] dwen_to_be(input logic [DWEN_W-1:0] dwen);
    logic [BE_W-1:0] be;
    be = '0;
    for (int i = 0; i < DWEN_W; i++) begin
      be[4*i +: 4] = {4{dwen[i]}};
    end
    return be;
  endfunction

endpackage

// File: rtl/dma_read_burst_writer.sv
// Drains burst descriptors and data beats from two show-ahead FIFO paths (A/B),
// round-robin per burst, into a valid/ready memory write port.
// Optional statistics counters: define DMA_BURST_WRITER_STATS_EN.
module dma_read_burst_writer
  import dma_read_burst_writer_pkg::*;
#(
  parameter int ADDR_STEP = 16,
  parameter int MAX_BEATS = 256
) (
  input  logic              i_clk,
  input  logic              i_rst,

  input  logic              a_burst_empty,
  input  logic [ADDR_W-1:0] a_burst_addr,
  input  logic [CTR_W-1:0]  a_burst_ctr,
  output logic              a_burst_rd_en,
  input  logic              b_burst_empty,
  input  logic [ADDR_W-1:0] b_burst_addr,
  input  logic [CTR_W-1:0]  b_burst_ctr,
  output logic              b_burst_rd_en,

  input  logic              a_data_empty,
  input  logic [BEAT_W-1:0] a_data_dout,
  input  logic [DWEN_W-1:0] a_data_dwen,
  output logic              a_data_rd_en,
  input  logic              b_data_empty,
  input  logic [BEAT_W-1:0] b_data_dout,
  input  logic [DWEN_W-1:0] b_data_dwen,
  output logic              b_data_rd_en,

  output logic [ADDR_W-1:0] mem_addr,
  output logic [BEAT_W-1:0] mem_data,
  output logic [BE_W-1:0]   mem_be,
  output logic              mem_valid,
  input  logic              mem_ready,

  output logic              busy,
  output logic [31:0]       stat_bursts,
  output logic [31:0]       stat_beats
);

  localparam int REM_W = $clog2(MAX_BEATS + 1);

  state_t            r_state;
  logic              r_sel_b;
  logic              r_prio_b;
  logic              r_a_burst_rd_en;
  logic              r_b_burst_rd_en;
  logic [ADDR_W-1:0] r_addr;
  logic [REM_W-1:0]  r_remaining;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [BEAT_W-1:0] r_mem_data;
  logic [BE_W-1:0]   r_mem_be;
  logic              r_mem_valid;

  logic              w_req_a;
  logic              w_req_b;
  logic              w_pick_b;
  logic              w_out_free;
  logic              w_sel_data_empty;
  logic              w_pop;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [CTR_W-1:0]  w_sel_ctr;
  logic [BEAT_W-1:0] w_sel_dout;
  logic [DWEN_W-1:0] w_sel_dwen;

  assign w_req_a  = !a_burst_empty;
  assign w_req_b  = !b_burst_empty;
  // B wins when it alone requests, or on a tie when the pointer favours it.
  assign w_pick_b = w_req_b && (!w_req_a || r_prio_b);

  assign w_sel_addr       = r_sel_b ? b_burst_addr : a_burst_addr;
  assign w_sel_ctr        = r_sel_b ? b_burst_ctr  : a_burst_ctr;
  assign w_sel_dout       = r_sel_b ? b_data_dout  : a_data_dout;
  assign w_sel_dwen       = r_sel_b ? b_data_dwen  : a_data_dwen;
  assign w_sel_data_empty = r_sel_b ? b_data_empty : a_data_empty;

  // The pop is combinational so back-to-back beats need no bubble; reset gates it
  // so an abandoned burst never consumes another beat.
  assign w_out_free = !r_mem_valid || mem_ready;
  assign w_pop      = !i_rst && (r_state == ST_BEAT) && w_out_free && !w_sel_data_empty;

  assign a_data_rd_en  = w_pop && !r_sel_b;
  assign b_data_rd_en  = w_pop &&  r_sel_b;
  assign a_burst_rd_en = r_a_burst_rd_en && !i_rst;
  assign b_burst_rd_en = r_b_burst_rd_en && !i_rst;

  assign mem_addr  = r_mem_addr;
  assign mem_data  = r_mem_data;
  assign mem_be    = r_mem_be;
  assign mem_valid = r_mem_valid;
  assign busy      = (r_state != ST_IDLE) || r_mem_valid;

  // Burst FSM, arbiter pointer, address/beat bookkeeping and output register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state         <= ST_IDLE;
      r_sel_b         <= 1'b0;
      r_prio_b        <= 1'b0;
      r_a_burst_rd_en <= 1'b0;
      r_b_burst_rd_en <= 1'b0;
      r_addr          <= '0;
      r_remaining     <= '0;
      r_mem_addr      <= '0;
      r_mem_data      <= '0;
      r_mem_be        <= '0;
      r_mem_valid     <= 1'b0;
    end else begin
      r_a_burst_rd_en <= 1'b0;
      r_b_burst_rd_en <= 1'b0;

      if (w_pop) begin
        r_mem_addr  <= r_addr;
        r_mem_data  <= w_sel_dout;
        r_mem_be    <= dwen_to_be(w_sel_dwen);
        r_mem_valid <= 1'b1;
      end else if (mem_ready) begin
        r_mem_valid <= 1'b0;
      end else begin
        r_mem_valid <= r_mem_valid;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_req_a || w_req_b) begin
            r_sel_b         <= w_pick_b;
            r_prio_b        <= !w_pick_b;
            r_a_burst_rd_en <= !w_pick_b;
            r_b_burst_rd_en <= w_pick_b;
            r_state         <= ST_LOAD;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          r_addr      <= w_sel_addr;
          r_remaining <= REM_W'(w_sel_ctr) + REM_W'(1);
          r_state     <= ST_BEAT;
        end
        ST_BEAT: begin
          if (w_pop) begin
            r_addr      <= r_addr + ADDR_W'(ADDR_STEP);
            r_remaining <= r_remaining - REM_W'(1);
            if (r_remaining == REM_W'(1)) begin
              r_state <= ST_IDLE;
            end else begin
              r_state <= ST_BEAT;
            end
          end else begin
            r_state <= ST_BEAT;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef DMA_BURST_WRITER_STATS_EN
  logic [31:0] r_stat_bursts;
  logic [31:0] r_stat_beats;

  // Wrapping counters: one per descriptor load, one per accepted write.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stat_bursts <= 32'd0;
      r_stat_beats  <= 32'd0;
    end else begin
      if (r_state == ST_LOAD) begin
        r_stat_bursts <= r_stat_bursts + 32'd1;
      end else begin
        r_stat_bursts <= r_stat_bursts;
      end
      if (r_mem_valid && mem_ready) begin
        r_stat_beats <= r_stat_beats + 32'd1;
      end else begin
        r_stat_beats <= r_stat_beats;
      end
    end
  end

  assign stat_bursts = r_stat_bursts;
  assign stat_beats  = r_stat_beats;
`else
  assign stat_bursts = 32'd0;
  assign stat_beats  = 32'd0;
`endif

endmodule

// File: tb/tb_dma_read_burst_writer.sv
// Directed bench for dma_read_burst_writer: show-ahead FIFO models on both paths,
// scoreboard of expected memory writes, hold/stall, arbitration, wrap and reset checks.
module tb_dma_read_burst_writer;

  localparam int ADDR_STEP = 16;

  typedef struct {logic [31:0] addr; logic [7:0] ctr;} desc_t;
  typedef struct {logic [127:0] data; logic [3:0] dwen;} beat_t;
  typedef struct {logic [31:0] addr; logic [127:0] data; logic [15:0] be;} wr_t;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         a_burst_empty, b_burst_empty;
  logic [31:0]  a_burst_addr, b_burst_addr;
  logic [7:0]   a_burst_ctr, b_burst_ctr;
  logic         a_burst_rd_en, b_burst_rd_en;
  logic         a_data_empty, b_data_empty;
  logic [127:0] a_data_dout, b_data_dout;
  logic [3:0]   a_data_dwen, b_data_dwen;
  logic         a_data_rd_en, b_data_rd_en;
  logic [31:0]  mem_addr;
  logic [127:0] mem_data;
  logic [15:0]  mem_be;
  logic         mem_valid;
  logic         mem_ready;
  logic         busy;
  logic [31:0]  stat_bursts, stat_beats;

  desc_t qba[$], qbb[$];
  beat_t qda[$], qdb[$];
  wr_t   exp_q[$];
  int    hs_cyc[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_hs = 0;
  int pops_da = 0, pops_db = 0, pops_ba = 0, pops_bb = 0;
  int exp_bursts = 0, exp_beats = 0;
  logic pop_da = 1'b0, pop_db = 1'b0, pop_ba = 1'b0, pop_bb = 1'b0;
  logic        stall_prev = 1'b0;
  logic [31:0] prev_addr, last_hs_addr;
  logic [127:0] prev_data;
  logic [15:0] prev_be;

  dma_read_burst_writer #(.ADDR_STEP(ADDR_STEP), .MAX_BEATS(256)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .a_burst_empty(a_burst_empty), .a_burst_addr(a_burst_addr), .a_burst_ctr(a_burst_ctr),
    .a_burst_rd_en(a_burst_rd_en),
    .b_burst_empty(b_burst_empty), .b_burst_addr(b_burst_addr), .b_burst_ctr(b_burst_ctr),
    .b_burst_rd_en(b_burst_rd_en),
    .a_data_empty(a_data_empty), .a_data_dout(a_data_dout), .a_data_dwen(a_data_dwen),
    .a_data_rd_en(a_data_rd_en),
    .b_data_empty(b_data_empty), .b_data_dout(b_data_dout), .b_data_dwen(b_data_dwen),
    .b_data_rd_en(b_data_rd_en),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_be(mem_be), .mem_valid(mem_valid),
    .mem_ready(mem_ready),
    .busy(busy), .stat_bursts(stat_bursts), .stat_beats(stat_beats)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [127:0] beat_data(input logic [31:0] a, input int i, input bit pb);
    return {a, ~a, 32'hC0DE_0000 | 32'(i), 31'd0, pb};
  endfunction

  function automatic logic [31:0] exp_stat(input int n);
`ifdef DMA_BURST_WRITER_STATS_EN
    return 32'(n);
`else
    return 32'd0 & 32'(n);
`endif
  endfunction

  // FIFO model: pop at +1 after the edge on strobes sampled at the preceding negedge,
  // then refresh the show-ahead heads at +3 (after stimulus written at +2).
  initial begin
    a_burst_empty = 1'b1; b_burst_empty = 1'b1; a_data_empty = 1'b1; b_data_empty = 1'b1;
    a_burst_addr = '0; a_burst_ctr = '0; b_burst_addr = '0; b_burst_ctr = '0;
    a_data_dout = '0; a_data_dwen = '0; b_data_dout = '0; b_data_dwen = '0;
    forever begin
      @(posedge i_clk);
      #1;
      if (pop_da && qda.size() > 0) begin void'(qda.pop_front()); pops_da++; end
      if (pop_db && qdb.size() > 0) begin void'(qdb.pop_front()); pops_db++; end
      if (pop_ba && qba.size() > 0) begin void'(qba.pop_front()); pops_ba++; end
      if (pop_bb && qbb.size() > 0) begin void'(qbb.pop_front()); pops_bb++; end
      #2;
      a_burst_empty = (qba.size() == 0);
      b_burst_empty = (qbb.size() == 0);
      a_data_empty  = (qda.size() == 0);
      b_data_empty  = (qdb.size() == 0);
      a_burst_addr  = (qba.size() > 0) ? qba[0].addr : 32'd0;
      a_burst_ctr   = (qba.size() > 0) ? qba[0].ctr  : 8'd0;
      b_burst_addr  = (qbb.size() > 0) ? qbb[0].addr : 32'd0;
      b_burst_ctr   = (qbb.size() > 0) ? qbb[0].ctr  : 8'd0;
      a_data_dout   = (qda.size() > 0) ? qda[0].data : 128'd0;
      a_data_dwen   = (qda.size() > 0) ? qda[0].dwen : 4'd0;
      b_data_dout   = (qdb.size() > 0) ? qdb[0].data : 128'd0;
      b_data_dwen   = (qdb.size() > 0) ? qdb[0].dwen : 4'd0;
    end
  end

  // Monitor at the falling edge: strobe sampling, hold checks, scoreboard compare.
  initial begin
    wr_t w;
    forever begin
      @(negedge i_clk);
      cyc++;
      pop_da = a_data_rd_en; pop_db = b_data_rd_en;
      pop_ba = a_burst_rd_en; pop_bb = b_burst_rd_en;
      if (!i_rst) begin
        if (stall_prev) begin
          chk("hold_valid", 128'(mem_valid), 128'd1);
          chk("hold_addr", 128'(mem_addr), 128'(prev_addr));
          chk("hold_data", mem_data, prev_data);
          chk("hold_be", 128'(mem_be), 128'(prev_be));
        end
        if (mem_valid && mem_ready) begin
          n_hs++;
          hs_cyc.push_back(cyc);
          last_hs_addr = mem_addr;
          if (exp_q.size() == 0) begin
            chk("unexpected_write", 128'(exp_q.size()), 128'd1);
          end else begin
            w = exp_q.pop_front();
            chk("wr_addr", 128'(mem_addr), 128'(w.addr));
            chk("wr_data", mem_data, w.data);
            chk("wr_be", 128'(mem_be), 128'(w.be));
          end
        end
        stall_prev = mem_valid && !mem_ready;
        prev_addr = mem_addr; prev_data = mem_data; prev_be = mem_be;
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #2;
  endtask

  task automatic add_data(input bit pb, input logic [31:0] addr, input logic [7:0] ctr,
                          input logic [3:0] last_dwen, input int from, input int to);
    beat_t b;
    logic [31:0] ba;
    for (int i = from; i <= to; i++) begin
      ba     = addr + 32'(ADDR_STEP * i);
      b.data = beat_data(ba, i, pb);
      b.dwen = (i == int'(ctr)) ? last_dwen : 4'hF;
      if (pb) qdb.push_back(b); else qda.push_back(b);
    end
  endtask

  task automatic send_burst(input bit pb, input logic [31:0] addr, input logic [7:0] ctr,
                            input logic [3:0] last_dwen, input logic [15:0] last_be,
                            input int n_data);
    desc_t d;
    wr_t w;
    d.addr = addr; d.ctr = ctr;
    if (pb) qbb.push_back(d); else qba.push_back(d);
    exp_bursts++;
    for (int i = 0; i <= int'(ctr); i++) begin
      w.addr = addr + 32'(ADDR_STEP * i);
      w.data = beat_data(w.addr, i, pb);
      w.be   = (i == int'(ctr)) ? last_be : 16'hFFFF;
      exp_q.push_back(w);
      exp_beats++;
    end
    add_data(pb, addr, ctr, last_dwen, 0, n_data - 1);
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || busy) && k < 200) begin
      tick();
      k++;
    end
    chk(tag, 128'(exp_q.size() == 0 && !busy), 128'd1);
  endtask

  task automatic wait_hs(input int target, input string tag);
    int k;
    k = 0;
    while (n_hs < target && k < 100) begin
      tick();
      k++;
    end
    chk(tag, 128'(n_hs >= target), 128'd1);
  endtask

  task automatic do_reset();
    tick();
    i_rst = 1'b1;
    tick();
    tick();
    chk("rst_valid", 128'(mem_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_rd_en", 128'({a_burst_rd_en, b_burst_rd_en, a_data_rd_en, b_data_rd_en}), 128'd0);
    chk("rst_addr", 128'(mem_addr), 128'd0);
    chk("rst_data", mem_data, 128'd0);
    chk("rst_be", 128'(mem_be), 128'd0);
    chk("rst_stat_bursts", 128'(stat_bursts), 128'd0);
    chk("rst_stat_beats", 128'(stat_beats), 128'd0);
    qba.delete(); qbb.delete(); qda.delete(); qdb.delete(); exp_q.delete();
    exp_bursts = 0; exp_beats = 0;
    i_rst = 1'b0;
  endtask

  initial begin
    int base, pd;
    i_rst = 1'b1;
    mem_ready = 1'b1;
    do_reset();

    // Single full burst at one beat per cycle.
    hs_cyc.delete();
    send_burst(1'b0, 32'h0000_1000, 8'd3, 4'hF, 16'hFFFF, 4);
    wait_drain("drain_basic");
    chk("basic_count", 128'(hs_cyc.size()), 128'd4);
    for (int i = 0; i < 3 && i + 1 < hs_cyc.size(); i++)
      chk("basic_consecutive", 128'(hs_cyc[i+1] - hs_cyc[i]), 128'd1);
    chk("stat_bursts_1", 128'(stat_bursts), 128'(exp_stat(exp_bursts)));
    chk("stat_beats_1", 128'(stat_beats), 128'(exp_stat(exp_beats)));

    // Partial dword enables on the final beat.
    send_burst(1'b0, 32'h0000_2000, 8'd1, 4'b0011, 16'h00FF, 2);
    wait_drain("drain_partial_be");

    // Arbitration: A1, A2 and B1 pending together after reset -> A1, B1, A2.
    do_reset();
    send_burst(1'b0, 32'h0000_3000, 8'd1, 4'hF, 16'hFFFF, 2);
    send_burst(1'b1, 32'h0000_4000, 8'd2, 4'b0001, 16'h000F, 3);
    send_burst(1'b0, 32'h0000_5000, 8'd0, 4'hF, 16'hFFFF, 1);
    wait_drain("drain_arbitration");
    chk("arb_desc_pops", 128'({pops_ba[7:0], pops_bb[7:0]}), 128'({8'd4, 8'd1}));
    chk("stat_bursts_3", 128'(stat_bursts), 128'(exp_stat(exp_bursts)));

    // Back-pressure and data underrun mid-burst.
    base = n_hs;
    pd = pops_da;
    send_burst(1'b0, 32'h0000_6000, 8'd5, 4'hF, 16'hFFFF, 3);
    wait_hs(base + 2, "stall_reach");
    mem_ready = 1'b0;
    repeat (5) tick();
    chk("stall_no_extra_pop", 128'(pops_da - pd), 128'd3);
    mem_ready = 1'b1;
    repeat (4) tick();
    add_data(1'b0, 32'h0000_6000, 8'd5, 4'hF, 3, 5);
    wait_drain("drain_stall");
    chk("stall_writes", 128'(n_hs - base), 128'd6);
    chk("stall_pops", 128'(pops_da - pd), 128'd6);

    // Address wrap across 2^32.
    send_burst(1'b0, 32'hFFFF_FFF0, 8'd1, 4'hF, 16'hFFFF, 2);
    wait_drain("drain_wrap");
    chk("wrap_addr", 128'(last_hs_addr), 128'd0);

    // Reset in the middle of an 8-beat burst.
    base = n_hs;
    send_burst(1'b1, 32'h0000_7000, 8'd7, 4'hF, 16'hFFFF, 8);
    wait_hs(base + 2, "mid_rst_reach");
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    chk("mid_rst_valid", 128'(mem_valid), 128'd0);
    chk("mid_rst_stats", 128'({stat_bursts, stat_beats}), 128'd0);
    qba.delete(); qbb.delete(); exp_q.delete();
    pd = pops_db;
    for (int i = 0; i < 5; i++) begin
      chk("mid_rst_no_pop", 128'({a_data_rd_en, b_data_rd_en, a_burst_rd_en, b_burst_rd_en}), 128'd0);
      tick();
    end
    chk("mid_rst_pop_count", 128'(pops_db - pd), 128'd0);
    chk("mid_rst_idle", 128'(busy), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
